// File: rtl/async_chan_arbiter.sv
// Round-robin arbiter that lets N clocked four-phase requesters share one
// self-timed channel whose acknowledge arrives asynchronously to clk.
module async_chan_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   req_i,
  input  logic [N*W-1:0] data_i,
  output logic [N-1:0]   ack_o,
  output logic           out_req,
  output logic [W-1:0]   out_data,
  input  logic           out_ack,
  output logic [N-1:0]   grant_o,
  output logic           busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, RELEASE} state_t;

  state_t        state, state_d;
  logic [PW-1:0] ptr, ptr_d;
  logic          ack_meta, ack_s;
  logic [N-1:0]  ack_d, grant_d;
  logic          out_req_d;
  logic [W-1:0]  out_data_d;
  logic [PW-1:0] win;
  logic          win_vld;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  // out_ack is the only asynchronous input; nothing else may look at it raw.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes a flop chain work.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= out_ack;
      ack_s    <= ack_meta;
    end
  end

  // Search upward from the requester after the last owner.
  always_comb begin
    win     = ptr;
    win_vld = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!win_vld && req_i[wrap_add(ptr, k)]) begin
        win     = wrap_add(ptr, k);
        win_vld = 1'b1;
      end
    end
  end

  // NOTE: every signal written here gets a hold-value default first, so no
  // path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    ack_d      = ack_o;
    grant_d    = grant_o;
    out_req_d  = out_req;
    out_data_d = out_data;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_d      = ISSUE;
          ptr_d        = win;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          out_data_d   = data_i[int'(win)*W +: W];
          out_req_d    = 1'b1;
        end
      end
      ISSUE: begin
        // The owner dropping its request here is a protocol error and is ignored.
        if (ack_s) begin
          state_d = HOLD;
          ack_d   = grant_o;
        end
      end
      HOLD: begin
        if (!req_i[ptr]) begin
          state_d   = RELEASE;
          out_req_d = 1'b0;
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          state_d = IDLE;
          ack_d   = '0;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      ptr      <= PW'(N - 1);
      ack_o    <= '0;
      grant_o  <= '0;
      out_req  <= 1'b0;
      out_data <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      ack_o    <= ack_d;
      grant_o  <= grant_d;
      out_req  <= out_req_d;
      out_data <= out_data_d;
      busy     <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_async_chan_arbiter.sv
// Self-checking bench for async_chan_arbiter: a table of round-robin
// transactions plus directed sequences for fairness, glitches and reset.
module tb_async_chan_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   grant;
    logic [W-1:0]   dout;
  } vec_t;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   req_i = '0;
  logic [N*W-1:0] data_i = '0;
  logic [N-1:0]   ack_o, grant_o;
  logic           out_req, busy;
  logic           out_ack = 1'b0;
  logic [W-1:0]   out_data;

  int n_pass  = 0;
  int n_total = 0;
  int ack_dly = 3;
  bit rand_off = 1'b0;
  bit bad_ack = 1'b0;
  bit bad_x = 1'b0;
  int ack2_cycles = 0;

  async_chan_arbiter #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_i    (req_i),
    .data_i   (data_i),
    .ack_o    (ack_o),
    .out_req  (out_req),
    .out_data (out_data),
    .out_ack  (out_ack),
    .grant_o  (grant_o),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Self-timed channel: acknowledge follows the request after a delay that
  // lands at an arbitrary point inside a clock period.
  always begin
    @(out_req);
    repeat (ack_dly) @(posedge clk);
    if (rand_off) #($urandom_range(2, 8));
    else #3;
    out_ack = out_req;
  end

  always @(negedge clk) begin
    if (rstn) begin
      if ($isunknown({ack_o, grant_o, out_req, out_data, busy})) bad_x = 1'b1;
      if (!$onehot0(ack_o) || ((ack_o & ~grant_o) != '0)) bad_ack = 1'b1;
      if (ack_o[2]) ack2_cycles++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 30) begin tick(); n++; end
    check({tag, "_idle"}, 32'({busy, ack_o, grant_o, out_req}), 32'(0));
  endtask

  task automatic wait_ack(input string tag, input logic [N-1:0] exp);
    int n;
    n = 0;
    while (ack_o === '0 && n < 30) begin tick(); n++; end
    check({tag, "_ack"}, 32'(ack_o), 32'(exp));
  endtask

  // Full four-phase transaction with cycle-exact checks at each phase.
  task automatic run_txn(input vec_t v, input string tag);
    int n;
    data_i = v.data;
    req_i  = v.req;
    tick();
    check({tag, "_grant"}, 32'(grant_o), 32'(v.grant));
    check({tag, "_out_req"}, 32'({out_req, busy}), 32'(2'b11));
    check({tag, "_data"}, 32'(out_data), 32'(v.dout));
    n = 0;
    while (out_ack !== 1'b1 && n < 20) begin tick(); n++; end
    check({tag, "_chan_ack"}, 32'(out_ack), 32'(1));
    tick();
    check({tag, "_ack_early"}, 32'(ack_o), 32'(0));
    tick();
    check({tag, "_ack_2clk"}, 32'(ack_o), 32'(v.grant));
    data_i = ~v.data;
    req_i  = '0;
    tick();
    check({tag, "_release"}, 32'({out_req, ack_o}), 32'({1'b0, v.grant}));
    check({tag, "_data_hold"}, 32'(out_data), 32'(v.dout));
    wait_idle(tag);
  endtask

  initial begin
    vec_t vecs[7];
    vec_t v;
    int   c0;

    vecs[0] = '{4'b0001, 32'h443322A5, 4'b0001, 8'hA5};
    vecs[1] = '{4'b0101, 32'h1E2D3C4B, 4'b0100, 8'h2D};
    vecs[2] = '{4'b0101, 32'h0F1E2D3C, 4'b0001, 8'h3C};
    vecs[3] = '{4'b1010, 32'hDEADBEEF, 4'b0010, 8'hBE};
    vecs[4] = '{4'b1001, 32'h8899AABB, 4'b1000, 8'h88};
    vecs[5] = '{4'b1000, 32'h77665544, 4'b1000, 8'h77};
    vecs[6] = '{4'b0110, 32'hCAFEF00D, 4'b0010, 8'hF0};

    repeat (3) tick();
    check("reset_state", 32'({out_req, busy, ack_o, grant_o, out_data}), 32'(0));
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Fairness: all four requesting, owner re-raises after completion.
    rstn = 1'b0;
    repeat (6) tick();
    rstn = 1'b1;
    tick();
    data_i = 32'h43322110;
    req_i  = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      int n;
      logic [N-1:0] own;
      n = 0;
      while (grant_o === '0 && n < 30) begin tick(); n++; end
      own = grant_o;
      check($sformatf("fair_grant%0d", g), 32'(grant_o), 32'(1) << (g % N));
      check($sformatf("fair_data%0d", g), 32'(out_data), 32'(16 + 17 * (g % N)));
      wait_ack($sformatf("fair%0d", g), own);
      req_i = req_i & ~own;
      n = 0;
      while (grant_o !== '0 && n < 30) begin tick(); n++; end
      req_i = 4'b1111;
    end
    req_i = '0;
    wait_idle("fair_end");

    // Requester 2 pulses while requester 1 owns the channel.
    c0     = ack2_cycles;
    data_i = 32'h00001100;
    req_i  = 4'b0010;
    tick();
    check("glitch_grant", 32'(grant_o), 32'(4'b0010));
    req_i = 4'b0110;
    tick();
    req_i = 4'b0010;
    wait_ack("glitch", 4'b0010);
    req_i = '0;
    wait_idle("glitch");
    repeat (5) tick();
    check("glitch_no_grant", 32'(grant_o), 32'(0));
    check("glitch_no_ack2", 32'(ack2_cycles - c0), 32'(0));

    // Owner withdraws during ISSUE: handshake still waits for the channel.
    data_i = 32'h99000000;
    req_i  = 4'b1000;
    tick();
    check("issue_drop_grant", 32'(grant_o), 32'(4'b1000));
    req_i = '0;
    tick();
    tick();
    check("issue_drop_hold", 32'({out_req, busy, ack_o}), 32'({2'b11, 4'b0000}));
    wait_ack("issue_drop", 4'b1000);
    check("issue_drop_data", 32'(out_data), 32'(8'h99));
    wait_idle("issue_drop");

    // Reset in HOLD clears outputs without a clock; pointer restarts at N-1.
    data_i = 32'h000000C3;
    req_i  = 4'b0001;
    wait_ack("rst_mid", 4'b0001);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_async", 32'({out_req, busy, ack_o, grant_o, out_data}), 32'(0));
    req_i = 4'b1001;
    repeat (6) tick();
    rstn = 1'b1;
    #2;
    check("rst_release_quiet", 32'({out_req, grant_o}), 32'(0));
    tick();
    check("rst_first_grant", 32'(grant_o), 32'(4'b0001));
    wait_ack("rst_after", 4'b0001);
    req_i = '0;
    wait_idle("rst_after");

    // Channel acknowledge at random phases relative to clk.
    rand_off = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ack_dly = int'($urandom_range(1, 3));
      v.req   = 4'(1 << i);
      v.data  = $urandom;
      v.grant = v.req;
      v.dout  = v.data[i*W +: W];
      run_txn(v, $sformatf("rand%0d", i));
    end

    check("one_hot_ack", 32'(bad_ack), 32'(0));
    check("no_x", 32'(bad_x), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
